// File: rtl/or1200_fpu_pkg.sv
// Shared definitions for the FPU issue controller: opcode encodings, FSM
// state encoding and the canonical quiet NaN returned on watchdog expiry.
package or1200_fpu_pkg;

  localparam int unsigned FPU_OP_W   = 8;
  localparam int unsigned FPU_DATA_W = 32;

  // Bit 7 of an opcode marks it as a legal FPU operation
  localparam int unsigned FPU_OP_VALID_BIT = 7;

  localparam logic [FPU_OP_W-1:0] FPU_OP_ADD = 8'h00;
  localparam logic [FPU_OP_W-1:0] FPU_OP_SUB = 8'h01;
  localparam logic [FPU_OP_W-1:0] FPU_OP_MUL = 8'h02;
  localparam logic [FPU_OP_W-1:0] FPU_OP_DIV = 8'h03;
  localparam logic [FPU_OP_W-1:0] FPU_OP_I2F = 8'h04;
  localparam logic [FPU_OP_W-1:0] FPU_OP_F2I = 8'h05;
  localparam logic [FPU_OP_W-1:0] FPU_OP_REM = 8'h06;

  localparam logic [FPU_DATA_W-1:0] FPU_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fpu_state_e;

  function automatic logic is_legal_op(input logic [FPU_OP_W-1:0] op);
    return op[FPU_OP_VALID_BIT];
  endfunction

endpackage

// File: rtl/or1200_fpu_watchdog.sv
// Clearable up-counter that flags when an FPU operation has been pending
// for LIMIT cycles.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous clear (asserted the cycle before counting starts)
//   run       : count enable (high while waiting on the FPU)
//   expire_c  : combinational; high in the LIMIT-th running cycle
module or1200_fpu_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  assign expire_c = run && (count == LAST);

  // Counter saturates at LAST so it never wraps while the FSM reacts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expire_c) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/or1200_fpu_issue_ctrl.sv
// Single-outstanding issue controller placed in front of or1200_fpu.
// Accepts a request, drives op/operands to the FPU until done, then holds the
// captured response until the consumer accepts it.
// Optional feature: define FPU_TIMEOUT_EN to add a WAIT-state watchdog that
// returns a qNaN timeout response after TIMEOUT_CYCLES.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_op, req_a, req_b, req_tag     request payload
//   fpu_op, fpu_a, fpu_b              FPU command (op is 0 when not issuing)
//   fpu_done, fpu_result, fpu_flagforw, fpu_flag_we, fpu_sig   FPU completion
//   rsp_valid/rsp_ready               response handshake
//   rsp_result, rsp_flag, rsp_flag_we, rsp_exc, rsp_illegal, rsp_timeout, rsp_tag
//   busy                              high whenever the FSM is not IDLE
module or1200_fpu_issue_ctrl #(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [7:0]       fpu_op,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_flagforw,
  input  logic             fpu_flag_we,
  input  logic             fpu_sig,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_flag,
  output logic             rsp_flag_we,
  output logic             rsp_exc,
  output logic             rsp_illegal,
  output logic             rsp_timeout,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  import or1200_fpu_pkg::*;

  fpu_state_e         state;
  logic [FPU_OP_W-1:0] op_q;
  logic                timeout_hit;

`ifdef FPU_TIMEOUT_EN
  logic wd_clear;
  logic wd_run;

  // Counter is cleared during ISSUE so it starts at zero on WAIT entry
  assign wd_clear = (state == ST_ISSUE);
  assign wd_run   = (state == ST_WAIT);

  or1200_fpu_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .run      (wd_run),
    .expire_c (timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // Issue FSM with all handshake and FPU-facing outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      fpu_op      <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flag    <= 1'b0;
      rsp_flag_we <= 1'b0;
      rsp_exc     <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_tag     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            fpu_a       <= req_a;
            fpu_b       <= req_b;
            rsp_tag     <= req_tag;
            rsp_result  <= '0;
            rsp_flag    <= 1'b0;
            rsp_flag_we <= 1'b0;
            rsp_exc     <= 1'b0;
            rsp_timeout <= 1'b0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            if (is_legal_op(req_op)) begin
              rsp_illegal <= 1'b0;
              state       <= ST_ISSUE;
            end else begin
              // Illegal op short-circuits to a response without touching the FPU
              rsp_illegal <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end

        ST_ISSUE: begin
          fpu_op <= op_q;
          state  <= ST_WAIT;
        end

        ST_WAIT: begin
          // Completion takes priority over a simultaneous watchdog expiry
          if (fpu_done) begin
            rsp_result  <= fpu_result;
            rsp_flag    <= fpu_flagforw;
            rsp_flag_we <= fpu_flag_we;
            rsp_exc     <= fpu_sig;
            fpu_op      <= '0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_result  <= FPU_QNAN;
            rsp_exc     <= 1'b1;
            rsp_timeout <= 1'b1;
            fpu_op      <= '0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_fpu_issue_ctrl.sv
// Directed self-checking bench for or1200_fpu_issue_ctrl. The FPU is modelled
// by the stimulus itself: done pulses are driven by hand with known results.
`timescale 1ns/1ps
module tb_or1200_fpu_issue_ctrl;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [7:0]       fpu_op;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic             fpu_done;
  logic [31:0]      fpu_result;
  logic             fpu_flagforw;
  logic             fpu_flag_we;
  logic             fpu_sig;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_flag;
  logic             rsp_flag_we;
  logic             rsp_exc;
  logic             rsp_illegal;
  logic             rsp_timeout;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  or1200_fpu_issue_ctrl #(
    .TAG_W          (TAG_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .fpu_op       (fpu_op),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_done     (fpu_done),
    .fpu_result   (fpu_result),
    .fpu_flagforw (fpu_flagforw),
    .fpu_flag_we  (fpu_flag_we),
    .fpu_sig      (fpu_sig),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flag     (rsp_flag),
    .rsp_flag_we  (rsp_flag_we),
    .rsp_exc      (rsp_exc),
    .rsp_illegal  (rsp_illegal),
    .rsp_timeout  (rsp_timeout),
    .rsp_tag      (rsp_tag),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock and settle 1ns past the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
  endtask

  task automatic fpu_complete(input logic [31:0] res, input logic flag, input logic fwe,
                              input logic sig);
    fpu_done     = 1'b1;
    fpu_result   = res;
    fpu_flagforw = flag;
    fpu_flag_we  = fwe;
    fpu_sig      = sig;
    step();
    fpu_done     = 1'b0;
    fpu_result   = 32'h0;
    fpu_flagforw = 1'b0;
    fpu_flag_we  = 1'b0;
    fpu_sig      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    fpu_done = 1'b0; fpu_result = '0; fpu_flagforw = 1'b0; fpu_flag_we = 1'b0;
    fpu_sig = 1'b0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_fpu_op",    32'(fpu_op),    32'h00);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_timeout",   32'(rsp_timeout), 32'd0);

    // DIV with done after 5 cycles in WAIT
    send(8'h83, 32'h3FCCCCCD, 32'h40800000, 4'h5);
    step();
    req_valid = 1'b0;
    check("div_issue_ready", 32'(req_ready), 32'd0);
    check("div_issue_busy",  32'(busy),      32'd1);
    check("div_issue_op0",   32'(fpu_op),    32'h00);
    step();
    check("div_fpu_op", 32'(fpu_op), 32'h83);
    for (int i = 0; i < 4; i++) begin
      check("div_a_stable", fpu_a, 32'h3FCCCCCD);
      check("div_b_stable", fpu_b, 32'h40800000);
      check("div_op_stable", 32'(fpu_op), 32'h83);
      step();
    end
    check("div_no_early_rsp", 32'(rsp_valid), 32'd0);
    fpu_complete(32'h3ECCCCCD, 1'b0, 1'b0, 1'b0);
    check("div_rsp_valid",  32'(rsp_valid),   32'd1);
    check("div_rsp_result", rsp_result,       32'h3ECCCCCD);
    check("div_rsp_tag",    32'(rsp_tag),     32'h5);
    check("div_rsp_illegal",32'(rsp_illegal), 32'd0);
    check("div_fpu_op_off", 32'(fpu_op),      32'h00);

    // Backpressure: response held, new request and stray done ignored
    send(8'h80, 32'h3F800000, 32'h40000000, 4'h9);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) fpu_complete(32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
      else step();
      check("bp_rsp_valid",  32'(rsp_valid), 32'd1);
      check("bp_rsp_result", rsp_result,     32'h3ECCCCCD);
      check("bp_rsp_tag",    32'(rsp_tag),   32'h5);
      check("bp_req_ready",  32'(req_ready), 32'd0);
    end
    check("bp_flag_hold", 32'(rsp_exc), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_rsp_drop",   32'(rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_busy",  32'(busy),      32'd0);
    step();
    req_valid = 1'b0;
    check("bp2_accept_busy", 32'(busy), 32'd1);
    step();
    check("bp2_fpu_op", 32'(fpu_op), 32'h80);
    check("bp2_fpu_a",  fpu_a,       32'h3F800000);
    fpu_complete(32'h40400000, 1'b1, 1'b1, 1'b1);
    check("bp2_result",  rsp_result,        32'h40400000);
    check("bp2_flag",    32'(rsp_flag),     32'd1);
    check("bp2_flag_we", 32'(rsp_flag_we),  32'd1);
    check("bp2_exc",     32'(rsp_exc),      32'd1);
    check("bp2_tag",     32'(rsp_tag),      32'h9);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Illegal opcode bypasses the FPU
    send(8'h03, 32'h11111111, 32'h22222222, 4'h3);
    step();
    req_valid = 1'b0;
    check("ill_rsp_valid", 32'(rsp_valid),   32'd1);
    check("ill_flag",      32'(rsp_illegal), 32'd1);
    check("ill_result",    rsp_result,       32'h0);
    check("ill_exc",       32'(rsp_exc),     32'd0);
    check("ill_tag",       32'(rsp_tag),     32'h3);
    check("ill_fpu_op",    32'(fpu_op),      32'h00);
    step();
    check("ill_fpu_op_hold", 32'(fpu_op), 32'h00);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("ill_rsp_done", 32'(rsp_valid), 32'd0);

    // Reset while waiting on the FPU
    send(8'h82, 32'h40000000, 32'h40400000, 4'h7);
    step();
    req_valid = 1'b0;
    step();
    step();
    check("rw_pre_fpu_op", 32'(fpu_op), 32'h82);
    rst = 1'b1;
    #1;
    check("rw_fpu_op",    32'(fpu_op),    32'h00);
    check("rw_busy",      32'(busy),      32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    fpu_complete(32'h40C00000, 1'b0, 1'b0, 1'b0);
    check("rw_stray_done", 32'(rsp_valid), 32'd0);
    check("rw_stray_busy", 32'(busy),      32'd0);

`ifdef FPU_TIMEOUT_EN
    // Watchdog expiry with TIMEOUT_CYCLES=8 and no done
    begin
      int waited;
      send(8'h83, 32'h3F800000, 32'h00000000, 4'hA);
      step();
      req_valid = 1'b0;
      step();
      waited = 0;
      while (!rsp_valid && waited < 40) begin
        step();
        waited++;
      end
      check("to_wait_cycles", 32'(waited),      32'd8);
      check("to_timeout",     32'(rsp_timeout), 32'd1);
      check("to_result",      rsp_result,       32'h7FC00000);
      check("to_exc",         32'(rsp_exc),     32'd1);
      check("to_fpu_op",      32'(fpu_op),      32'h00);
      check("to_tag",         32'(rsp_tag),     32'hA);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
`else
    // Without the watchdog WAIT holds indefinitely and timeout stays low
    send(8'h83, 32'h3F800000, 32'h3F800000, 4'hA);
    step();
    req_valid = 1'b0;
    step();
    repeat (20) step();
    check("nto_still_wait", 32'(rsp_valid),   32'd0);
    check("nto_fpu_op",     32'(fpu_op),      32'h83);
    fpu_complete(32'h3F800000, 1'b0, 1'b0, 1'b0);
    check("nto_rsp_valid",  32'(rsp_valid),   32'd1);
    check("nto_timeout",    32'(rsp_timeout), 32'd0);
    check("nto_result",     rsp_result,       32'h3F800000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
